parte_controllo: RTL

PARTE_CONTROLLO -- requirements
Module: parte_controllo

---
 rtl/pc_pkg.sv | 26 ++
 rtl/contatore_sat.sv | 25 ++
 rtl/parte_controllo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the Sigma/Omega controller: FSM states,
// control words {mux1,mux2,wea,web,aluctl} per state, counter width.
package pc_pkg;

  localparam int ITER_W = 8;
  localparam int CYC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_ADD,
    S_DEC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [4:0] CW_IDLE = 5'b00000;
  localparam logic [4:0] CW_INIT = 5'b00110;
  localparam logic [4:0] CW_TEST = 5'b00000;
  localparam logic [4:0] CW_ADD  = 5'b10101;
  localparam logic [4:0] CW_DEC  = 5'b01011;
  localparam logic [4:0] CW_DONE = 5'b00000;
  localparam logic [4:0] CW_ERR  = 5'b00000;

endpackage

// File: rtl/contatore_sat.sv
// Saturating up-counter with clear and enable.
// Ports: clock, reset (async high), clr, en, q[WIDTH-1:0].
module contatore_sat #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // clr together with en restarts at 1 so the
  // clearing cycle itself is counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= {{(WIDTH-1){1'b0}}, en};
    end else if (en && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/parte_controllo.sv
// Moore control unit for the Sigma/Omega multiply-by-add datapath.
// Ports: clock, reset (async high), start, zero -> mux1, mux2, wea,
// web, aluctl, busy, done, err; with PARTE_CONTROLLO_STATS_EN also
// cycles[15:0] = busy cycles of the last run.
module parte_controllo
  import pc_pkg::*;
#(
  parameter int MAX_ITER = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        zero,
  output logic        mux1,
  output logic        mux2,
  output logic        wea,
  output logic        web,
  output logic        aluctl,
  output logic        busy,
  output logic        done,
`ifdef PARTE_CONTROLLO_STATS_EN
  output logic [15:0] cycles,
`endif
  output logic        err
);

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  state_t              state;
  state_t              nxt;
  logic [4:0]          cw;
  logic [ITER_W-1:0]   iter;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Outputs depend on state only; inputs steer nxt alone.
  always_comb begin
    nxt  = state;
    cw   = CW_IDLE;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_INIT;
      end
      S_INIT: begin
        cw   = CW_INIT;
        busy = 1'b1;
        nxt  = S_TEST;
      end
      S_TEST: begin
        cw   = CW_TEST;
        busy = 1'b1;
        // completion wins over the watchdog
        if (zero) begin
          nxt = S_DONE;
        end else if (iter == LIMIT) begin
          nxt = S_ERR;
        end else begin
          nxt = S_ADD;
        end
      end
      S_ADD: begin
        cw   = CW_ADD;
        busy = 1'b1;
        nxt  = S_DEC;
      end
      S_DEC: begin
        cw   = CW_DEC;
        busy = 1'b1;
        nxt  = S_TEST;
      end
      S_DONE: begin
        cw   = CW_DONE;
        done = 1'b1;
        nxt  = S_IDLE;
      end
      S_ERR: begin
        cw  = CW_ERR;
        err = 1'b1;
        if (!start) nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  assign {mux1, mux2, wea, web, aluctl} = cw;

  // One count per ADD visit; TEST sees the number of
  // completed ADD/DEC passes.
  contatore_sat #(
    .WIDTH (ITER_W)
  ) u_iter (
    .clock (clock),
    .reset (reset),
    .clr   (state == S_INIT),
    .en    (state == S_ADD),
    .q     (iter)
  );

`ifdef PARTE_CONTROLLO_STATS_EN
  contatore_sat #(
    .WIDTH (CYC_W)
  ) u_cyc (
    .clock (clock),
    .reset (reset),
    .clr   (state == S_INIT),
    .en    (busy),
    .q     (cycles)
  );
`endif

endmodule
